// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational MIPS-style ALU between two requesters.
// Operands are registered for one settle cycle. The result is captured and returned with the owner ID.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 6
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_aluc,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_aluc,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_aluc,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_negative,
    input  logic             alu_overflow,
    input  logic             alu_flag,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_r,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic             rsp_flag,
    output logic             rsp_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_last_grant;
    logic             r_legal;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [OPW-1:0]   r_alu_aluc;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_r;
    logic             r_rsp_zero;
    logic             r_rsp_overflow;
    logic             r_rsp_flag;
    logic             r_rsp_err;

    logic             w_gnt0;
    logic             w_gnt1;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [OPW-1:0]   w_sel_aluc;
    logic             w_is_cmp;
    logic             w_unused_flags;

    function automatic logic is_legal(input logic [OPW-1:0] op);
        logic ok;
        case (op)
            6'b100000, 6'b100001, 6'b100010, 6'b100011,
            6'b100100, 6'b100101, 6'b100110, 6'b100111,
            6'b101010, 6'b101011,
            6'b000000, 6'b000010, 6'b000011, 6'b000100,
            6'b000110, 6'b000111, 6'b001111: ok = 1'b1;
            default:                         ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Contention goes to whichever requester did not win last time.
    always_comb begin
        w_gnt0     = req0_valid && (!req1_valid || r_last_grant);
        w_gnt1     = req1_valid && (!req0_valid || !r_last_grant);
        w_sel_a    = w_gnt1 ? req1_a    : req0_a;
        w_sel_b    = w_gnt1 ? req1_b    : req0_b;
        w_sel_aluc = w_gnt1 ? req1_aluc : req0_aluc;
        w_is_cmp   = (r_alu_aluc == 6'b101010) || (r_alu_aluc == 6'b101011);
    end

    assign w_unused_flags = alu_carry ^ alu_negative;

    assign req0_ready   = !rst && (r_state == IDLE) && w_gnt0;
    assign req1_ready   = !rst && (r_state == IDLE) && w_gnt1;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_aluc     = r_alu_aluc;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_r        = r_rsp_r;
    assign rsp_zero     = r_rsp_zero;
    assign rsp_overflow = r_rsp_overflow;
    assign rsp_flag     = r_rsp_flag;
    assign rsp_err      = r_rsp_err;
    assign busy         = (r_state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_last_grant   <= 1'b1;
            r_legal        <= 1'b0;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_aluc     <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= 1'b0;
            r_rsp_r        <= '0;
            r_rsp_zero     <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_rsp_flag     <= 1'b0;
            r_rsp_err      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_alu_a      <= w_sel_a;
                        r_alu_b      <= w_sel_b;
                        r_alu_aluc   <= w_sel_aluc;
                        r_rsp_id     <= w_gnt1;
                        r_last_grant <= w_gnt1;
                        r_legal      <= is_legal(w_sel_aluc);
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Illegal opcodes never sample the ALU, so an undriven result cannot leak out.
                    if (r_legal) begin
                        r_rsp_r        <= alu_r;
                        r_rsp_zero     <= alu_zero;
                        r_rsp_overflow <= alu_overflow;
                        r_rsp_flag     <= w_is_cmp ? alu_flag : 1'b0;
                        r_rsp_err      <= 1'b0;
                    end else begin
                        r_rsp_r        <= '0;
                        r_rsp_zero     <= 1'b0;
                        r_rsp_overflow <= 1'b0;
                        r_rsp_flag     <= 1'b0;
                        r_rsp_err      <= 1'b1;
                    end
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural ALU drives the ALU inputs.
// Illegal ops drive visible junk so that the gating of the response path can be observed.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [5:0]  req0_aluc, req1_aluc;
    logic [31:0] alu_a, alu_b, alu_r;
    logic [5:0]  alu_aluc;
    logic        alu_zero, alu_carry, alu_negative, alu_overflow, alu_flag;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_overflow, rsp_flag, rsp_err, busy;
    logic [31:0] rsp_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32), .OPW(6)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_aluc(req0_aluc),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_aluc(req1_aluc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_r(alu_r),
        .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_negative(alu_negative),
        .alu_overflow(alu_overflow), .alu_flag(alu_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_r(rsp_r),
        .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .rsp_flag(rsp_flag), .rsp_err(rsp_err),
        .busy(busy)
    );

    // Behavioural ALU; non-compare ops raise alu_flag, and illegal ops return junk.
    always_comb begin
        logic cmp;
        alu_r        = 32'hDEADBEEF;
        alu_overflow = 1'b1;
        alu_carry    = 1'b0;
        cmp          = 1'b0;
        case (alu_aluc)
            6'b100000, 6'b100001: begin
                alu_r = alu_a + alu_b;
                alu_overflow = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);
            end
            6'b100010, 6'b100011: begin
                alu_r = alu_a - alu_b;
                alu_overflow = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
            end
            6'b100100: begin alu_r = alu_a & alu_b;    alu_overflow = 1'b0; end
            6'b100101: begin alu_r = alu_a | alu_b;    alu_overflow = 1'b0; end
            6'b100110: begin alu_r = alu_a ^ alu_b;    alu_overflow = 1'b0; end
            6'b100111: begin alu_r = ~(alu_a | alu_b); alu_overflow = 1'b0; end
            6'b101010: begin alu_r = {31'd0, $signed(alu_a) < $signed(alu_b)}; alu_overflow = 1'b0; cmp = 1'b1; end
            6'b101011: begin alu_r = {31'd0, alu_a < alu_b}; alu_overflow = 1'b0; cmp = 1'b1; end
            6'b000000, 6'b000100: begin alu_r = alu_b << alu_a[4:0]; alu_overflow = 1'b0; end
            6'b000010, 6'b000110: begin alu_r = alu_b >> alu_a[4:0]; alu_overflow = 1'b0; end
            6'b000011, 6'b000111: begin alu_r = $signed(alu_b) >>> alu_a[4:0]; alu_overflow = 1'b0; end
            6'b001111: begin alu_r = {alu_b[15:0], 16'h0}; alu_overflow = 1'b0; end
            default: ;
        endcase
        alu_zero     = (alu_r == 32'd0);
        alu_negative = alu_r[31];
        alu_flag     = cmp ? alu_r[0] : 1'b1;
    end

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  op;
        logic [31:0] r;
        logic        z;
        logic        o;
        logic        f;
        logic        e;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called just after a negedge; drives the request, waits (bounded) for ready, checks latency and response.
    task automatic run_vec(input int idx, input vec_t v);
        bit got = 0;
        if (v.id) begin req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_aluc = v.op; end
        else      begin req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_aluc = v.op; end
        for (int n = 0; n < 10 && !got; n++) begin
            #1;
            if (v.id ? req1_ready : req0_ready) got = 1;
            else @(negedge clk);
        end
        chk($sformatf("v%0d_ready", idx), {31'd0, got}, 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (!got) return;
        chk($sformatf("v%0d_issue_valid", idx), {31'd0, rsp_valid}, 32'd0);
        chk($sformatf("v%0d_alu_a", idx), alu_a, v.a);
        chk($sformatf("v%0d_alu_b", idx), alu_b, v.b);
        chk($sformatf("v%0d_alu_aluc", idx), {26'd0, alu_aluc}, {26'd0, v.op});
        @(negedge clk);
        chk($sformatf("v%0d_rsp_valid", idx), {31'd0, rsp_valid}, 32'd1);
        chk($sformatf("v%0d_rsp_id", idx), {31'd0, rsp_id}, {31'd0, v.id});
        chk($sformatf("v%0d_rsp_r", idx), rsp_r, v.r);
        chk($sformatf("v%0d_flags_zofe", idx),
            {28'd0, rsp_zero, rsp_overflow, rsp_flag, rsp_err}, {28'd0, v.z, v.o, v.f, v.e});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk($sformatf("v%0d_done", idx), {30'd0, rsp_valid, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        vecs[0]  = '{1'b0, 32'd5,        32'd7,        6'b100000, 32'd12,        1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'hFFFFFFFF, 32'd1,        6'b101010, 32'd1,         1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 32'hFFFFFFFF, 32'd1,        6'b101011, 32'd0,         1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'd3,        32'd4,        6'b001000, 32'd0,         1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 32'd9,        32'd9,        6'b100011, 32'd0,         1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 32'h000000F0, 32'h0000000F, 6'b100101, 32'h000000FF,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 32'h7FFFFFFF, 32'd1,        6'b100000, 32'h80000000,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 32'd4,        32'd1,        6'b000000, 32'h00000010,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 32'd0,        32'h00001234, 6'b001111, 32'h12340000,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 32'd1,        32'd2,        6'b111111, 32'd0,         1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 32'd4,        32'h80000000, 6'b000011, 32'hF8000000,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 32'd0,        32'd0,        6'b100111, 32'hFFFFFFFF,  1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_aluc = 6'b100000;
        req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_aluc = 6'b100000;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        chk("rst_alu", alu_a | alu_b | {26'd0, alu_aluc}, 32'd0);
        chk("rst_rsp", {29'd0, rsp_valid, rsp_err, busy}, 32'd0);
        chk("rst_rsp_r", rsp_r, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);
        chk("alu_hold", {26'd0, alu_aluc}, {26'd0, 6'b100111});

        // Fairness: both continuously valid after reset, responses must go 0,1,0,1.
        do_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd9;    req0_b = 32'd9;    req0_aluc = 6'b100011;
        req1_valid = 1'b1; req1_a = 32'hF0;   req1_b = 32'h0F;   req1_aluc = 6'b100101;
        seen = 0;
        for (int n = 0; n < 40 && seen < 4; n++) begin
            @(negedge clk);
            chk("fair_one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
            if (rsp_valid) begin
                chk($sformatf("fair%0d_id", seen), {31'd0, rsp_id}, {31'd0, seen[0]});
                chk($sformatf("fair%0d_r", seen), rsp_r, seen[0] ? 32'hFF : 32'd0);
                chk($sformatf("fair%0d_zero", seen), {31'd0, rsp_zero}, {31'd0, !seen[0]});
                seen++;
            end
        end
        chk("fair_count", seen, 4);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) @(negedge clk);
        rsp_ready = 1'b0;

        // Back-pressure: pending response held 5 cycles while req1 waits.
        req0_valid = 1'b1; req0_a = 32'd20; req0_b = 32'd22; req0_aluc = 6'b100000;
        #1;
        chk("bp_accept", {31'd0, req0_ready}, 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd6; req1_b = 32'd2; req1_aluc = 6'b100010;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d_rsp", c), {rsp_valid, rsp_id, rsp_zero, rsp_overflow, rsp_flag, rsp_err, 26'd0},
                {1'b1, 1'b0, 4'b0000, 26'd0});
            chk($sformatf("bp%0d_r", c), rsp_r, 32'd42);
            chk($sformatf("bp%0d_req1_ready", c), {31'd0, req1_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("bp_grant_req1", {30'd0, req1_ready, rsp_valid}, 32'd2);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        chk("bp_req1_rsp", {rsp_valid, rsp_id, 30'd0}, {2'b11, 30'd0});
        chk("bp_req1_r", rsp_r, 32'd4);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset while ISSUE: in-flight response discarded; requester 0 wins afterwards.
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_aluc = 6'b100000;
        @(negedge clk);
        req0_valid = 1'b0;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("mid_rst_out", {29'd0, rsp_valid, busy, req0_ready | req1_ready}, 32'd0);
        @(negedge clk);
        chk("mid_rst_hold", {30'd0, rsp_valid, busy}, 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_first_grant", {30'd0, req0_ready, req1_ready}, 32'd2);
        chk("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("mid_new_rsp", {rsp_valid, rsp_id, 30'd0}, {2'b10, 30'd0});
        chk("mid_new_r", rsp_r, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
